// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: byte-addressed register bank behind an SPI slave, with read-only status at the top address.
// Build option: define SPI_REG_CTRL_AUTOINC_EN to auto-increment the address pointer within a frame.
module spi_reg_ctrl #(
   parameter int         NUM_REGS  = 16,
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic                  i_RX_DV,
   input  logic [7:0]            i_RX_Byte,
   output logic                  o_TX_DV,
   output logic [7:0]            o_TX_Byte,
   input  logic                  i_SPI_CS_n,
   input  logic [7:0]            i_Status,
   output logic [8*NUM_REGS-1:0] o_Regs,
   output logic                  o_Wr_Pulse,
   output logic [7:0]            o_Err_Cnt
);

   localparam int         AW   = $clog2(NUM_REGS);
   localparam logic [7:0] LAST = 8'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_DATA = 2'd1,
      RD_DATA = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] cs_sync_q;
   logic       cs_end_s;
   logic [6:0] ptr_q, ptr_d;
   logic [6:0] rd_ptr_s;
   logic [7:0] rd_data_s;
   logic       rd_req_s, wr_en_s, err_s;
   logic [7:0] regs_q [NUM_REGS-1];
   logic       tx_dv_q, tx_dv_d;
   logic [7:0] tx_byte_q, tx_byte_d;
   logic       stat_pend_q, stat_pend_d;
   logic       wr_pulse_q;
   logic [7:0] err_cnt_q, err_cnt_d;

   assign cs_end_s = cs_sync_q[1] & ~cs_sync_q[2];

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q   <= IDLE;
         cs_sync_q <= 3'b111;
      end else begin
         state_q   <= state_d;
         cs_sync_q <= {cs_sync_q[1:0], i_SPI_CS_n};
      end
   end

   // Frame end wins, but the byte arriving with it is still decoded below.
   always_comb begin
      state_d = state_q;
      if (cs_end_s) begin
         state_d = IDLE;
      end else if (i_RX_DV) begin
         case (state_q)
            IDLE:    state_d = i_RX_Byte[7] ? RD_DATA : WR_DATA;
            WR_DATA: state_d = WR_DATA;
            RD_DATA: state_d = RD_DATA;
            default: state_d = IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_comb begin
      ptr_d       = ptr_q;
      rd_ptr_s    = ptr_q;
      rd_req_s    = 1'b0;
      wr_en_s     = 1'b0;
      err_s       = 1'b0;
      rd_data_s   = 8'h00;
      tx_dv_d     = 1'b0;
      tx_byte_d   = tx_byte_q;
      stat_pend_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      if (i_RX_DV) begin
         case (state_q)
            IDLE: begin
               ptr_d    = i_RX_Byte[6:0];
               rd_ptr_s = i_RX_Byte[6:0];
               rd_req_s = i_RX_Byte[7];
            end
            WR_DATA: begin
               if ({1'b0, ptr_q} < LAST) begin
                  wr_en_s = 1'b1;
               end else begin
                  err_s = 1'b1;
               end
`ifdef SPI_REG_CTRL_AUTOINC_EN
               ptr_d = ptr_q + 7'd1;
`else
               ptr_d = ptr_q;
`endif
            end
            RD_DATA: begin
`ifdef SPI_REG_CTRL_AUTOINC_EN
               ptr_d    = ptr_q + 7'd1;
               rd_ptr_s = ptr_q + 7'd1;
`else
               ptr_d    = ptr_q;
               rd_ptr_s = ptr_q;
`endif
               rd_req_s = 1'b1;
            end
            default: ptr_d = ptr_q;
         endcase
      end else begin
         ptr_d = ptr_q;
      end

      if ({1'b0, rd_ptr_s} == LAST) begin
         rd_data_s = i_Status;
      end else if ({1'b0, rd_ptr_s} < LAST) begin
         rd_data_s = regs_q[rd_ptr_s[AW-1:0]];
      end else begin
         rd_data_s = 8'h00;
         err_s     = err_s | rd_req_s;
      end

      // A status load that would abut the previous TX strobe is held back one cycle.
      if (cs_end_s || stat_pend_q) begin
         if (tx_dv_q) begin
            stat_pend_d = 1'b1;
         end else begin
            tx_dv_d   = 1'b1;
            tx_byte_d = i_Status;
         end
      end else if (rd_req_s) begin
         tx_dv_d   = 1'b1;
         tx_byte_d = rd_data_s;
      end else begin
         tx_dv_d = 1'b0;
      end

      if (err_s && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         ptr_q       <= 7'd0;
         tx_dv_q     <= 1'b0;
         tx_byte_q   <= 8'h00;
         stat_pend_q <= 1'b0;
         wr_pulse_q  <= 1'b0;
         err_cnt_q   <= 8'h00;
         for (int k = 0; k < NUM_REGS - 1; k++) begin
            regs_q[k] <= RESET_VAL;
         end
      end else begin
         ptr_q       <= ptr_d;
         tx_dv_q     <= tx_dv_d;
         tx_byte_q   <= tx_byte_d;
         stat_pend_q <= stat_pend_d;
         wr_pulse_q  <= wr_en_s;
         err_cnt_q   <= err_cnt_d;
         if (wr_en_s) begin
            regs_q[ptr_q[AW-1:0]] <= i_RX_Byte;
         end
      end
   end

   // The top slot is the read-only status address; it has no storage.
   always_comb begin
      o_Regs = {(8*NUM_REGS){1'b0}};
      for (int k = 0; k < NUM_REGS - 1; k++) begin
         o_Regs[8*k +: 8] = regs_q[k];
      end
      o_Regs[8*(NUM_REGS-1) +: 8] = RESET_VAL;
   end

   assign o_TX_DV    = tx_dv_q;
   assign o_TX_Byte  = tx_byte_q;
   assign o_Wr_Pulse = wr_pulse_q;
   assign o_Err_Cnt  = err_cnt_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed vector table, hand-built corner sequences and random frames vs. a frame-level model.
module tb_spi_reg_ctrl;

   localparam int NREGS = 16;
`ifdef SPI_REG_CTRL_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, rx_dv, cs_n;
   logic [7:0]   rx_byte, status;
   logic         tx_dv, wr_pulse;
   logic [7:0]   tx_byte, err_cnt;
   logic [127:0] regs;

   int n_checks = 0;
   int n_fail   = 0;
   int tx_pulses = 0, wr_pulses = 0, tx_double = 0, wr_double = 0;
   logic prev_tx = 1'b0, prev_wr = 1'b0;

   logic [7:0] m_regs [NREGS];
   int         m_err, m_ptr;
   logic       m_rd;

   typedef struct packed {
      logic [7:0] b0, b1, b2;
      int         n;
      int         a0;
      logic [7:0] v0;
      int         a1;
      logic [7:0] v1;
      int         wr;
      int         err;
   } vec_t;
   vec_t tbl [6];

   spi_reg_ctrl #(.NUM_REGS(NREGS), .RESET_VAL(8'h00)) dut (
      .i_Clk(clk), .i_Rst(rst), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
      .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte), .i_SPI_CS_n(cs_n), .i_Status(status),
      .o_Regs(regs), .o_Wr_Pulse(wr_pulse), .o_Err_Cnt(err_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_dv) begin
         tx_pulses <= tx_pulses + 1;
         if (prev_tx) tx_double <= tx_double + 1;
      end
      if (wr_pulse) begin
         wr_pulses <= wr_pulses + 1;
         if (prev_wr) wr_double <= wr_double + 1;
      end
      prev_tx <= tx_dv;
      prev_wr <= wr_pulse;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] reg_of(input int k);
      return regs[8*k +: 8];
   endfunction

   task automatic send_byte(input logic [7:0] b, output logic tv, output logic [7:0] tb, output logic wp);
      rx_dv   = 1'b1;
      rx_byte = b;
      tick();
      rx_dv   = 1'b0;
      rx_byte = 8'h00;
      tv = tx_dv;
      tb = tx_byte;
      wp = wr_pulse;
      repeat (3) tick();
   endtask

   task automatic start_frame();
      cs_n = 1'b0;
      repeat (4) tick();
   endtask

   task automatic end_frame();
      cs_n = 1'b1;
      repeat (3) tick();
      check("idle_entry_tx_dv", 128'(tx_dv), 128'(1'b1));
      check("idle_entry_status", 128'(tx_byte), 128'(status));
      tick();
      check("idle_entry_single", 128'(tx_dv), 128'(1'b0));
      repeat (2) tick();
   endtask

   task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
      logic tv, wp;
      logic [7:0] tb;
      start_frame();
      send_byte(b0, tv, tb, wp);
      if (n > 1) send_byte(b1, tv, tb, wp);
      if (n > 2) send_byte(b2, tv, tb, wp);
      end_frame();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (3) tick();
   endtask

   // Reference model: frame-level interpretation of command/data bytes.
   task automatic m_read(output logic [7:0] v);
      if (m_ptr == NREGS - 1) v = status;
      else if (m_ptr < NREGS - 1) v = m_regs[m_ptr];
      else begin
         v = 8'h00;
         m_err = (m_err < 255) ? m_err + 1 : 255;
      end
   endtask

   task automatic m_byte(input bit first, input logic [7:0] b, output logic etv, output logic [7:0] etb, output logic ewp);
      etv = 1'b0; etb = 8'h00; ewp = 1'b0;
      if (first) begin
         m_ptr = int'(b[6:0]);
         m_rd  = b[7];
         if (m_rd) begin etv = 1'b1; m_read(etb); end
      end else if (!m_rd) begin
         if (m_ptr < NREGS - 1) begin m_regs[m_ptr] = b; ewp = 1'b1; end
         else m_err = (m_err < 255) ? m_err + 1 : 255;
         if (AUTOINC) m_ptr = (m_ptr + 1) % 128;
      end else begin
         if (AUTOINC) m_ptr = (m_ptr + 1) % 128;
         etv = 1'b1;
         m_read(etb);
      end
   endtask

   function automatic logic [127:0] m_vec();
      logic [127:0] v;
      v = '0;
      for (int k = 0; k < NREGS - 1; k++) v[8*k +: 8] = m_regs[k];
      return v;
   endfunction

   initial begin
      logic       tv, wp, etv, ewp;
      logic [7:0] tb, etb, b;
      int         wr0, err0, txp0, n;
      logic [6:0] addr;

      if (AUTOINC) begin
         tbl[0] = '{8'h03, 8'h5A, 8'hC3, 3, 3, 8'h5A, 4, 8'hC3, 2, 0};
         tbl[1] = '{8'h0F, 8'h55, 8'h00, 2, 15, 8'h00, 3, 8'h5A, 0, 1};
         tbl[2] = '{8'h0E, 8'h99, 8'hAA, 3, 14, 8'h99, 15, 8'h00, 1, 1};
         tbl[3] = '{8'h00, 8'h12, 8'h34, 3, 0, 8'h12, 1, 8'h34, 2, 0};
         tbl[4] = '{8'h7F, 8'h01, 8'h02, 3, 0, 8'h02, 1, 8'h34, 1, 1};
         tbl[5] = '{8'h05, 8'hEE, 8'h00, 2, 5, 8'hEE, 4, 8'hC3, 1, 0};
      end else begin
         tbl[0] = '{8'h03, 8'h5A, 8'hC3, 3, 3, 8'hC3, 4, 8'h00, 2, 0};
         tbl[1] = '{8'h0F, 8'h55, 8'h00, 2, 15, 8'h00, 3, 8'hC3, 0, 1};
         tbl[2] = '{8'h0E, 8'h99, 8'hAA, 3, 14, 8'hAA, 15, 8'h00, 2, 0};
         tbl[3] = '{8'h00, 8'h12, 8'h34, 3, 0, 8'h34, 1, 8'h00, 2, 0};
         tbl[4] = '{8'h7F, 8'h01, 8'h02, 3, 0, 8'h34, 1, 8'h00, 0, 2};
         tbl[5] = '{8'h05, 8'hEE, 8'h00, 2, 5, 8'hEE, 4, 8'h00, 1, 0};
      end

      rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; cs_n = 1'b1; status = 8'h5C;
      repeat (2) tick();
      check("rst_tx_dv", 128'(tx_dv), 128'(1'b0));
      check("rst_tx_byte", 128'(tx_byte), 128'(8'h00));
      check("rst_wr_pulse", 128'(wr_pulse), 128'(1'b0));
      check("rst_err_cnt", 128'(err_cnt), 128'(8'h00));
      check("rst_regs", regs, 128'(0));
      rst = 1'b0;
      txp0 = tx_pulses;
      repeat (5) tick();
      check("no_tx_after_reset", 128'(tx_pulses - txp0), 128'(0));

      for (int i = 0; i < 6; i++) begin
         wr0  = wr_pulses;
         err0 = int'(err_cnt);
         send_frame(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].n);
         check($sformatf("vec%0d_reg_a", i), 128'(reg_of(tbl[i].a0)), 128'(tbl[i].v0));
         check($sformatf("vec%0d_reg_b", i), 128'(reg_of(tbl[i].a1)), 128'(tbl[i].v1));
         check($sformatf("vec%0d_wr_count", i), 128'(wr_pulses - wr0), 128'(tbl[i].wr));
         check($sformatf("vec%0d_err_delta", i), 128'(int'(err_cnt) - err0), 128'(tbl[i].err));
      end

      // Burst read of preloaded registers
      send_frame(8'h02, 8'h11, 8'h00, 2);
      send_frame(8'h03, 8'h22, 8'h00, 2);
      start_frame();
      send_byte(8'h82, tv, tb, wp);
      check("rd_cmd_tx_dv", 128'(tv), 128'(1'b1));
      check("rd_cmd_tx_byte", 128'(tb), 128'(8'h11));
      send_byte(8'h00, tv, tb, wp);
      check("rd_dummy_tx_dv", 128'(tv), 128'(1'b1));
      check("rd_dummy_tx_byte", 128'(tb), AUTOINC ? 128'(8'h22) : 128'(8'h11));
      send_byte(8'h00, tv, tb, wp);
      end_frame();

      // Status address: write rejected, read returns i_Status
      status = 8'hA7;
      err0 = int'(err_cnt);
      send_frame(8'h0F, 8'h55, 8'h00, 2);
      check("status_wr_reg15", 128'(reg_of(15)), 128'(8'h00));
      check("status_wr_err", 128'(int'(err_cnt) - err0), 128'(1));
      err0 = int'(err_cnt);
      start_frame();
      send_byte(8'h8F, tv, tb, wp);
      check("status_rd_byte", 128'(tb), 128'(8'hA7));
      end_frame();
      check("status_rd_no_err", 128'(int'(err_cnt) - err0), 128'(0));

      // Out-of-range read at 0x7F, then error-counter saturation
      err0 = int'(err_cnt);
      start_frame();
      send_byte(8'hFF, tv, tb, wp);
      check("oor_rd_byte", 128'(tb), 128'(8'h00));
      check("oor_rd_err", 128'(int'(err_cnt) - err0), 128'(1));
      send_byte(8'h00, tv, tb, wp);
      check("oor_rd_wrap_err", 128'(int'(err_cnt) - err0), AUTOINC ? 128'(1) : 128'(2));
      end_frame();
      wr0 = wr_pulses;
      for (int i = 0; i < 300; i++) send_frame(8'h40, 8'h55, 8'h00, 2);
      check("err_saturated", 128'(err_cnt), 128'(8'hFF));
      check("oor_no_wr_pulse", 128'(wr_pulses - wr0), 128'(0));

      // CS-end coincident with the data byte of a write
      status = 8'h3E;
      start_frame();
      send_byte(8'h01, tv, tb, wp);
      cs_n = 1'b1;
      repeat (2) tick();
      rx_dv = 1'b1; rx_byte = 8'h77;
      tick();
      rx_dv = 1'b0; rx_byte = 8'h00;
      check("csend_wr_pulse", 128'(wr_pulse), 128'(1'b1));
      check("csend_tx_dv", 128'(tx_dv), 128'(1'b1));
      check("csend_tx_status", 128'(tx_byte), 128'(8'h3E));
      check("csend_reg1", 128'(reg_of(1)), 128'(8'h77));
      tick();
      check("csend_tx_single", 128'(tx_dv), 128'(1'b0));
      repeat (2) tick();
      start_frame();
      send_byte(8'h81, tv, tb, wp);
      check("csend_next_frame_rd", 128'(tb), 128'(8'h77));
      end_frame();

      // Reset in the middle of a write frame
      wr0 = wr_pulses;
      start_frame();
      send_byte(8'h02, tv, tb, wp);
      rst = 1'b1;
      tick();
      check("midrst_tx_dv", 128'(tx_dv), 128'(1'b0));
      check("midrst_tx_byte", 128'(tx_byte), 128'(8'h00));
      check("midrst_err", 128'(err_cnt), 128'(8'h00));
      check("midrst_regs", regs, 128'(0));
      rst = 1'b0;
      repeat (3) tick();
      end_frame();
      check("midrst_no_wr", 128'(wr_pulses - wr0), 128'(0));
      send_frame(8'h06, 8'h3C, 8'h00, 2);
      check("midrst_next_reg6", 128'(reg_of(6)), 128'(8'h3C));
      check("midrst_next_wr", 128'(wr_pulses - wr0), 128'(1));

      // Random frames against the model
      do_reset();
      for (int k = 0; k < NREGS; k++) m_regs[k] = 8'h00;
      m_err = 0; m_ptr = 0; m_rd = 1'b0;
      for (int f = 0; f < 40; f++) begin
         status = 8'($urandom);
         n = $urandom_range(1, 4);
         start_frame();
         for (int i = 0; i < n; i++) begin
            if (i == 0) begin
               if ($urandom_range(0, 9) < 7) addr = 7'($urandom_range(0, 17));
               else addr = 7'($urandom_range(0, 127));
               b = {1'($urandom_range(0, 1)), addr};
            end else begin
               b = 8'($urandom);
            end
            m_byte(i == 0, b, etv, etb, ewp);
            send_byte(b, tv, tb, wp);
            check("rand_tx_dv", 128'(tv), 128'(etv));
            if (etv) check("rand_tx_byte", 128'(tb), 128'(etb));
            check("rand_wr_pulse", 128'(wp), 128'(ewp));
         end
         end_frame();
         check("rand_regs", regs, m_vec());
         check("rand_err_cnt", 128'(err_cnt), 128'(m_err));
      end

      check("tx_dv_single_cycle", 128'(tx_double), 128'(0));
      check("wr_pulse_single_cycle", 128'(wr_double), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
